u_control: RTL

Instruction sequencer and decoder for the BIP I core. Drives the 11-bit fetch address into `u_program_memory`, captures the 16-bit instruction it returns one clock later, decodes it, and issues per-instruction control strobes to the accumulator/ALU datapath and the data RAM. Owns the program counter and the fetch/decode/execute state machine, including halt.

---
 rtl/u_control_pkg.sv | 35 +++
 rtl/u_control_if.sv | 29 ++
 rtl/u_control_decoder.sv | 49 ++++
 rtl/u_control.sv | 81 ++++++++
 4 files changed

// File: rtl/u_control_pkg.sv
// Shared definitions for the BIP I sequencer: opcodes, FSM states,
// accumulator mux codes and the decoded control bundle.
package u_control_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic       rd_ram;
    logic       wr_ram;
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/u_control_if.sv
// Bus between the sequencer, program memory and the accumulator/RAM datapath.
// The master side is the sequencer.
interface u_control_if #(
  parameter int PC_WIDTH      = 11,
  parameter int OPERAND_WIDTH = 11
);
  logic [PC_WIDTH-1:0]      prog_address;
  logic [15:0]              instruction;
  logic [OPERAND_WIDTH-1:0] operand;
  logic                     rd_ram;
  logic                     wr_ram;
  logic                     wr_acc;
  logic [1:0]               sel_a;
  logic                     sel_b;
  logic                     alu_op;
  logic                     halted;

  modport master (
    output prog_address, operand, rd_ram, wr_ram, wr_acc,
           sel_a, sel_b, alu_op, halted,
    input  instruction
  );

  modport slave (
    input  prog_address, operand, rd_ram, wr_ram, wr_acc,
           sel_a, sel_b, alu_op, halted,
    output instruction
  );
endinterface

// File: rtl/u_control_decoder.sv
// Combinational opcode decoder; unlisted opcodes decode to an all-zero NOP.
module u_decoder
  import u_control_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT:  ctrl.is_halt = 1'b1;
      OP_STO:  ctrl.wr_ram  = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_RAM;
      end
      OP_LDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_IMM;
      end
      OP_ADD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
      end
      OP_ADDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = 1'b1;
      end
      OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.alu_op = 1'b1;
      end
      OP_SUBI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.alu_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/u_control.sv
// BIP I sequencer: 3-cycle fetch/decode/execute with halt. Strobes are
// registered at the DECODE->EXEC edge, so they are visible for the EXEC cycle.
module u_control
  import u_control_pkg::*;
#(
  parameter int PC_WIDTH      = 11,
  parameter int OPERAND_WIDTH = 11
) (
  input  logic       clock,
  input  logic       reset,
  u_control_if.master bus
);

  state_t                   state, next_state;
  ctrl_t                    dec, ctrl_next;
  logic [PC_WIDTH-1:0]      pc;
  logic [OPERAND_WIDTH-1:0] operand_q;
  logic                     rd_ram_q, wr_ram_q, wr_acc_q, sel_b_q, alu_op_q, halted_q;
  logic [1:0]               sel_a_q;

  u_decoder decoder_inst (
    .opcode (bus.instruction[15:11]),
    .ctrl   (dec)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Decoded controls pass through only in DECODE; every other state issues zeros.
  always_comb begin
    next_state = state;
    ctrl_next  = '0;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        ctrl_next  = dec;
        next_state = dec.is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc        <= '0;
      operand_q <= '0;
      rd_ram_q  <= 1'b0;
      wr_ram_q  <= 1'b0;
      wr_acc_q  <= 1'b0;
      sel_a_q   <= SELA_RAM;
      sel_b_q   <= 1'b0;
      alu_op_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      rd_ram_q <= ctrl_next.rd_ram;
      wr_ram_q <= ctrl_next.wr_ram;
      wr_acc_q <= ctrl_next.wr_acc;
      sel_a_q  <= ctrl_next.sel_a;
      sel_b_q  <= ctrl_next.sel_b;
      alu_op_q <= ctrl_next.alu_op;
      if (ctrl_next.is_halt) halted_q <= 1'b1;
      if (state == S_DECODE) operand_q <= bus.instruction[OPERAND_WIDTH-1:0];
      if (state == S_EXEC)   pc <= pc + PC_WIDTH'(1);
    end
  end

  assign bus.prog_address = pc;
  assign bus.operand      = operand_q;
  assign bus.rd_ram       = rd_ram_q;
  assign bus.wr_ram       = wr_ram_q;
  assign bus.wr_acc       = wr_acc_q;
  assign bus.sel_a        = sel_a_q;
  assign bus.sel_b        = sel_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.halted       = halted_q;

endmodule
